// File: rtl/bubble_sort.sv
// Iterative bubble sort over an N-element unsigned array: one compare-swap per cycle,
// with early exit on a swap-free pass and a registered result/done pulse in FINISH.
module bubble_sort #(
    parameter int N = 100,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] data_in  [0:N-1],
    output logic [W-1:0] data_out [0:N-1],
    output logic         busy,
    output logic         done
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'((N > 1) ? N - 2 : 0);

    typedef enum logic [1:0] {IDLE, SORT, FINISH} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  work [0:N-1];
    logic [IW-1:0] pass_cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          swapped;
    logic          do_swap;
    logic          any_swap;
    logic          pass_end;
    logic          last_pass;

    always_comb begin
        idx_nxt   = idx + 1'b1;
        do_swap   = work[idx] > work[idx_nxt];
        any_swap  = swapped | do_swap;
        pass_end  = (idx == LAST - pass_cnt);
        last_pass = (pass_cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (N == 1) ? FINISH : SORT;
                end
            end
            SORT: begin
                // Swap in this cycle counts toward the pass's early-exit decision.
                if (pass_end && (last_pass || !any_swap)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            pass_cnt <= '0;
            idx      <= '0;
            swapped  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                work[i]     <= '0;
                data_out[i] <= '0;
            end
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            work[i] <= data_in[i];
                        end
                        pass_cnt <= '0;
                        idx      <= '0;
                        swapped  <= 1'b0;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        work[idx]     <= work[idx_nxt];
                        work[idx_nxt] <= work[idx];
                    end
                    if (pass_end) begin
                        if (!last_pass && any_swap) begin
                            pass_cnt <= pass_cnt + 1'b1;
                            idx      <= '0;
                            swapped  <= 1'b0;
                        end
                    end else begin
                        idx     <= idx_nxt;
                        swapped <= any_swap;
                    end
                end
                FINISH: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        data_out[i] <= work[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bubble_sort.sv
// Directed bench for bubble_sort: scoreboard of sorted vectors and expected latencies,
// checked with immediate assertions when done pulses.
module tb_bubble_sort;
    localparam int N = 100;
    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din  [0:N-1];
    logic [W-1:0] dout [0:N-1];
    logic         busy;
    logic         done;

    int edges    = 0;
    int t0       = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q [$];
    int           lat_q [$];

    bubble_sort #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (din),
        .data_out (dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Compare cycles a bubble sort with early exit spends on the current din.
    function automatic int compare_count();
        logic [W-1:0] a [0:N-1];
        logic [W-1:0] tmp;
        int c = 0;
        bit sw;
        for (int i = 0; i < N; i++) a[i] = din[i];
        for (int p = 0; p <= N - 2; p++) begin
            sw = 1'b0;
            for (int j = 0; j <= N - 2 - p; j++) begin
                c++;
                if (a[j] > a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp; sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        return c;
    endfunction

    task automatic push_expect();
        logic [W-1:0] q [$];
        for (int i = 0; i < N; i++) q.push_back(din[i]);
        q.sort();
        foreach (q[i]) exp_q.push_back(q[i]);
        lat_q.push_back(compare_count() + 1);
    endtask

    task automatic discard();
        void'(lat_q.pop_front());
        for (int i = 0; i < N; i++) void'(exp_q.pop_front());
    endtask

    // Caller is at a negedge; start is sampled on the following posedge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = edges;
        check("busy_after_start", {31'b0, busy}, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, {31'b0, done}, 1);
        if (done === 1'b1) begin
            check({tag, "_latency"}, W'(edges - t0), W'(lat_q.pop_front()));
            for (int i = 0; i < N; i++) check({tag, "_data"}, dout[i], exp_q.pop_front());
        end else begin
            discard();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) din[i] = '0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        for (int i = 0; i < N; i++) check("rst_dout", dout[i], 0);
        @(negedge clk);
        rst = 1'b0;

        // Strictly descending: worst-case latency
        @(negedge clk);
        for (int i = 0; i < N; i++) din[i] = W'(N - 1 - i);
        push_expect();
        pulse_start();
        wait_done("desc", 6000);
        check("desc_lat_const", W'(edges - t0), 4951);
        @(negedge clk);
        check("done_pulse_one_cycle", {31'b0, done}, 0);
        check("idle_busy", {31'b0, busy}, 0);

        // Already sorted: single pass
        for (int i = 0; i < N; i++) din[i] = W'(i);
        push_expect();
        pulse_start();
        wait_done("asc", 300);
        check("asc_lat_const", W'(edges - t0), 100);

        // Mixed unsigned values with duplicates
        @(negedge clk);
        for (int i = 0; i < N; i++) din[i] = $urandom;
        din[0]  = 32'hFFFFFFFF;
        din[5]  = 32'h0;
        din[10] = 32'h80000000;
        din[11] = 32'h7FFFFFFF;
        din[20] = 32'd7;
        din[30] = 32'd7;
        din[40] = 32'd7;
        push_expect();
        pulse_start();
        wait_done("mixed", 6000);
        check("mixed_max_last", dout[N-1], 32'hFFFFFFFF);
        check("mixed_min_first", dout[0], 32'h0);

        // Start pulses while busy are ignored; data_out holds the previous result
        @(negedge clk);
        for (int i = 0; i < N; i++) din[i] = W'(N - 1 - i);
        push_expect();
        pulse_start();
        repeat (10) @(negedge clk);
        for (int i = 0; i < N; i++) din[i] = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_min", dout[0], 32'h0);
        check("hold_max", dout[N-1], 32'hFFFFFFFF);
        repeat (3000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_sort", {31'b0, busy}, 1);
        wait_done("busy_ign", 6000);

        // Back-to-back: start on the first IDLE cycle
        for (int i = 0; i < N; i++) din[i] = $urandom;
        push_expect();
        pulse_start();
        for (int i = 0; i < N; i++) din[i] = '0;
        @(negedge clk);
        check("b2b_done_low", {31'b0, done}, 0);
        repeat (10) @(negedge clk);
        check("b2b_hold_0", dout[0], 0);
        check("b2b_hold_50", dout[50], 50);
        check("b2b_hold_99", dout[99], 99);
        wait_done("b2b", 6000);

        // Reset mid-sort aborts without a done pulse
        @(negedge clk);
        for (int i = 0; i < N; i++) din[i] = W'(N - 1 - i);
        push_expect();
        pulse_start();
        repeat (2000) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        for (int i = 0; i < N; i++) check("abort_dout", dout[i], 0);
        discard();
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_done", {31'b0, done}, 0);
        for (int i = 0; i < N; i++) din[i] = $urandom;
        push_expect();
        pulse_start();
        wait_done("after_rst", 6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
